// File: rtl/mode_switch_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mode_switch_pipe_pkg
//  Description : Shared constants, mode encoding and lane helper for the
//                NTT/INTT mode switch pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mode_switch_pipe_pkg;

    localparam int WIDTH        = 13;
    localparam int MODULUS      = 7681;
    localparam int LANES        = 8;
    localparam int MULT_LAT     = 3;
    localparam int MAX_INFLIGHT = 32;
    localparam int DATA_W       = LANES * WIDTH;
    localparam int OCC_W        = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [0:0] {
        MODE_NTT  = 1'b0,
        MODE_INTT = 1'b1
    } mode_e;

    function automatic logic [WIDTH-1:0] lane_get(input logic [DATA_W-1:0] d, input int idx);
        return d[idx*WIDTH +: WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_switch_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : mode_switch_pipe_if
//  Description : Front, butterfly-facing and back stream signals of the mode
//                switch pipeline, plus mode control and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mode_switch_pipe_if;
    import mode_switch_pipe_pkg::*;

    logic              mode_req;
    logic              mode;
    logic              mode_busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] input_switch;
    logic [DATA_W-1:0] tw_in;
    logic              bf_in_valid;
    logic [DATA_W-1:0] butterfly_input;
    logic              bf_out_valid;
    logic [DATA_W-1:0] butterfly_output;
    logic [DATA_W-1:0] tw_out;
    logic              out_valid;
    logic [DATA_W-1:0] output_switch;
    logic              err;

    modport master (
        output mode_req, in_valid, input_switch, tw_in,
               bf_out_valid, butterfly_output, tw_out,
        input  mode, mode_busy, in_ready, bf_in_valid, butterfly_input,
               out_valid, output_switch, err
    );

    modport slave (
        input  mode_req, in_valid, input_switch, tw_in,
               bf_out_valid, butterfly_output, tw_out,
        output mode, mode_busy, in_ready, bf_in_valid, butterfly_input,
               out_valid, output_switch, err
    );

endinterface
`default_nettype wire

// File: rtl/mode_switch_pipe_mult.sv
`default_nettype none
// ============================================================================
//  Module      : mod_mult_pipe
//  Description : Pipelined modular multiplier, (a*b) mod MODULUS, with a
//                valid that travels alongside the data for MULT_LAT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_mult_pipe #(
    parameter int WIDTH    = 13,
    parameter int MODULUS  = 7681,
    parameter int MULT_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_p
);
    localparam int            PW  = 2 * WIDTH;
    localparam logic [PW-1:0] c_Q = PW'(MODULUS);

    logic [PW-1:0]       w_prod;
    logic [MULT_LAT-1:0] r_vld;
    logic [WIDTH-1:0]    r_p;

    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_valid;
            for (int i = 1; i < MULT_LAT; i++)
                r_vld[i] <= r_vld[i-1];
        end
    end

    // Raw product is registered first; the reduction sits in the last stage
    generate
        if (MULT_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) r_p <= '0;
                else     r_p <= WIDTH'(w_prod % c_Q);
            end
        end else begin : g_latn
            logic [PW-1:0] r_prod [MULT_LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prod <= '{default: '0};
                    r_p    <= '0;
                end else begin
                    r_prod[0] <= w_prod;
                    for (int i = 1; i < MULT_LAT - 1; i++)
                        r_prod[i] <= r_prod[i-1];
                    r_p <= WIDTH'(r_prod[MULT_LAT-2] % c_Q);
                end
            end
        end
    endgenerate

    assign o_valid = r_vld[MULT_LAT-1];
    assign o_p     = r_p;

endmodule
`default_nettype wire

// File: rtl/mode_switch_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mode_switch_pipe
//  Description : Multi-lane NTT/INTT mode switch: twiddle pre-multiply (NTT) or
//                post-multiply (INTT) with one shared multiplier per lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_switch_pipe
    import mode_switch_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mode_switch_pipe_if.slave bus
);
    mode_e               r_mode;
    mode_e               w_mode_nxt;
    logic [OCC_W-1:0]    r_occ;
    logic [OCC_W-1:0]    w_occ_nxt;
    logic                r_err;
    logic                w_ntt;
    logic                w_busy;
    logic                w_in_ready;
    logic                w_fire;
    logic                w_out_vld;
    logic                w_pipes_busy;
    logic [MULT_LAT-1:0] r_fd_vld;
    logic [MULT_LAT-1:0] r_bd_vld;
    logic [DATA_W-1:0]   r_fd_data [MULT_LAT];
    logic [DATA_W-1:0]   r_bd_data [MULT_LAT];
    logic                w_mult_in_vld;
    logic [LANES-1:0]    w_mult_vld;
    logic [DATA_W-1:0]   w_mult_p;

    assign w_ntt        = (r_mode == MODE_NTT);
    assign w_busy       = (bus.mode_req != r_mode);
    assign w_in_ready   = !w_busy && (r_occ < OCC_W'(MAX_INFLIGHT));
    assign w_fire       = bus.in_valid && w_in_ready;
    assign w_pipes_busy = (|r_fd_vld) || (|r_bd_vld);

    // The mode only moves once nothing is in flight, so the current mode is
    // always the mode every beat in the pipes entered with.
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_busy && (r_occ == '0) && !w_pipes_busy)
            w_mode_nxt = mode_e'(bus.mode_req);
    end

    always_ff @(posedge clk) begin
        if (rst) r_mode <= MODE_NTT;
        else     r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_fire && !w_out_vld)
            w_occ_nxt = r_occ + 1'b1;
        else if (!w_fire && w_out_vld && (r_occ != '0))
            w_occ_nxt = r_occ - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
            r_err <= 1'b0;
        end else begin
            r_occ <= w_occ_nxt;
            r_err <= r_err || (bus.bf_out_valid && (r_occ == '0));
        end
    end

    // Pass-through delay lines; their valids also serve as pipe occupancy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fd_vld  <= '0;
            r_bd_vld  <= '0;
            r_fd_data <= '{default: '0};
            r_bd_data <= '{default: '0};
        end else begin
            r_fd_vld[0]  <= w_fire;
            r_bd_vld[0]  <= bus.bf_out_valid;
            r_fd_data[0] <= bus.input_switch;
            r_bd_data[0] <= bus.butterfly_output;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_fd_vld[i]  <= r_fd_vld[i-1];
                r_bd_vld[i]  <= r_bd_vld[i-1];
                r_fd_data[i] <= r_fd_data[i-1];
                r_bd_data[i] <= r_bd_data[i-1];
            end
        end
    end

    assign w_mult_in_vld = w_ntt ? w_fire : bus.bf_out_valid;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_b;

            assign w_a = w_ntt ? lane_get(bus.input_switch, g) : lane_get(bus.butterfly_output, g);
            assign w_b = w_ntt ? lane_get(bus.tw_in, g)        : lane_get(bus.tw_out, g);

            mod_mult_pipe #(
                .WIDTH    (WIDTH),
                .MODULUS  (MODULUS),
                .MULT_LAT (MULT_LAT)
            ) u_mult (
                .clk     (clk),
                .rst     (rst),
                .i_valid (w_mult_in_vld),
                .i_a     (w_a),
                .i_b     (w_b),
                .o_valid (w_mult_vld[g]),
                .o_p     (w_mult_p[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign w_out_vld           = w_ntt ? r_bd_vld[MULT_LAT-1] : (&w_mult_vld);

    assign bus.mode            = r_mode;
    assign bus.mode_busy       = w_busy;
    assign bus.in_ready        = w_in_ready;
    assign bus.bf_in_valid     = w_ntt ? (&w_mult_vld) : r_fd_vld[MULT_LAT-1];
    assign bus.butterfly_input = w_ntt ? w_mult_p : r_fd_data[MULT_LAT-1];
    assign bus.out_valid       = w_out_vld;
    assign bus.output_switch   = w_ntt ? r_bd_data[MULT_LAT-1] : w_mult_p;
    assign bus.err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mode_switch_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mode_switch_pipe
//  Description : Self-checking bench for mode_switch_pipe (vector table plus
//                scoreboard of expected front/back beats with due cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_switch_pipe;
    import mode_switch_pipe_pkg::*;

    localparam int Q = 7681;

    typedef logic [DATA_W-1:0] vec_t;
    typedef struct { vec_t data; int due; } sb_t;
    typedef struct { logic mode; int a; int tw; int bo; int two; int exp_bi; int exp_os; } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_bfin = 0;
    int   n_out = 0;
    logic m_mode = 1'b0;
    sb_t  q_front[$];
    sb_t  q_back[$];

    mode_switch_pipe_if bus ();

    mode_switch_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t rep(input int v);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(v);
        return r;
    endfunction

    function automatic vec_t mk(input int seed);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'((seed * 131 + i * 977 + 5) % Q);
        return r;
    endfunction

    function automatic vec_t mulv(input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < LANES; i++)
            r[i*WIDTH +: WIDTH] = WIDTH'((longint'(a[i*WIDTH +: WIDTH]) * longint'(b[i*WIDTH +: WIDTH])) % Q);
        return r;
    endfunction

    // Scoreboard consumer: each expected beat must show up exactly on its due cycle
    always @(negedge clk) begin : mon
        sb_t e;
        if (!rst) begin
            if (q_front.size() > 0 && q_front[0].due == cyc) begin
                e = q_front.pop_front();
                chk("bf_in_valid", bus.bf_in_valid, 1);
                chk("butterfly_input", bus.butterfly_input, e.data);
            end else begin
                chk("bf_in_valid_idle", bus.bf_in_valid, 0);
            end
            if (q_back.size() > 0 && q_back[0].due == cyc) begin
                e = q_back.pop_front();
                chk("out_valid", bus.out_valid, 1);
                chk("output_switch", bus.output_switch, e.data);
            end else begin
                chk("out_valid_idle", bus.out_valid, 0);
            end
            if (bus.bf_in_valid) n_bfin++;
            if (bus.out_valid)   n_out++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_front(input vec_t d, input vec_t tw, input vec_t exp);
        bit ok;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.input_switch = d;
        bus.tw_in        = tw;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q_front.push_back('{exp, cyc + MULT_LAT});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("in_ready_timeout", bus.in_ready, 1);
    endtask

    task automatic send_back(input vec_t bo, input vec_t two, input vec_t exp);
        bus.bf_out_valid     = 1'b1;
        bus.butterfly_output = bo;
        bus.tw_out           = two;
        @(negedge clk);
        q_back.push_back('{exp, cyc + MULT_LAT});
        @(posedge clk);
        #1;
    endtask

    task automatic switch_mode(input logic m);
        bit done;
        done = 1'b0;
        bus.mode_req = m;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus.mode == m) done = 1'b1;
        end
        chk("mode_switch", bus.mode, m);
        chk("mode_busy_clear", bus.mode_busy, 0);
        m_mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv_t tv [9];
        int  n0;
        bit  seen;

        tv[0] = '{1'b0,    5,    3,    9, 1111,   15,    9};
        tv[1] = '{1'b1, 3000, 2222, 3000, 4000, 3000, 2278};
        tv[2] = '{1'b0, 7680, 7680,    0,   55,    1,    0};
        tv[3] = '{1'b0, 1234,    0, 7680, 7680,    0, 7680};
        tv[4] = '{1'b1,    0,  999, 7680,    2,    0, 7679};
        tv[5] = '{1'b0, 4000,    2,    1, 4000,  319,    1};
        tv[6] = '{1'b1, 7680,    3,    1,    1, 7680,    1};
        tv[7] = '{1'b0,  100,  100,  123,    0, 2319,  123};
        tv[8] = '{1'b1,   77,    0, 7680, 7680,   77,    1};

        bus.mode_req         = 1'b0;
        bus.in_valid         = 1'b0;
        bus.input_switch     = '0;
        bus.tw_in            = '0;
        bus.bf_out_valid     = 1'b0;
        bus.butterfly_output = '0;
        bus.tw_out           = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mode", bus.mode, 0);
        chk("rst_mode_busy", bus.mode_busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_butterfly_input", bus.butterfly_input, 0);
        chk("rst_output_switch", bus.output_switch, 0);
        chk("rst_err", bus.err, 0);
        tick(1);

        // Vector table, one beat per path per vector, switching mode as needed
        for (int k = 0; k < 9; k++) begin
            if (tv[k].mode != m_mode) switch_mode(tv[k].mode);
            send_front(rep(tv[k].a), rep(tv[k].tw), rep(tv[k].exp_bi));
            bus.in_valid = 1'b0;
            tick(1);
            send_back(rep(tv[k].bo), rep(tv[k].two), rep(tv[k].exp_os));
            bus.bf_out_valid = 1'b0;
            tick(MULT_LAT + 2);
        end

        // Streaming in INTT: both paths back to back at once
        n0 = n_bfin;
        fork
            begin
                for (int s = 0; s < 20; s++) send_front(mk(s), mk(s + 100), mk(s));
                bus.in_valid = 1'b0;
            end
            begin
                tick(2);
                for (int s = 0; s < 20; s++) send_back(mk(s + 200), mk(s + 300), mulv(mk(s + 200), mk(s + 300)));
                bus.bf_out_valid = 1'b0;
            end
        join
        tick(MULT_LAT + 2);
        chk("stream_intt_bfin_count", n_bfin - n0, 20);

        // Streaming in NTT: front burst, then back burst
        switch_mode(1'b0);
        n0 = n_out;
        for (int s = 0; s < 20; s++) send_front(mk(s + 400), mk(s + 500), mulv(mk(s + 400), mk(s + 500)));
        bus.in_valid = 1'b0;
        for (int s = 0; s < 20; s++) send_back(mk(s + 600), mk(s + 700), mk(s + 600));
        bus.bf_out_valid = 1'b0;
        tick(MULT_LAT + 2);
        chk("stream_ntt_out_count", n_out - n0, 20);

        // Cancelled switch request
        send_front(mk(800), mk(801), mulv(mk(800), mk(801)));
        bus.in_valid = 1'b0;
        bus.mode_req = 1'b1;
        @(negedge clk);
        chk("cancel_busy", bus.mode_busy, 1);
        chk("cancel_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.mode_req = 1'b0;
        send_back(mk(802), mk(803), mk(802));
        bus.bf_out_valid = 1'b0;
        tick(MULT_LAT + 4);
        @(negedge clk);
        chk("cancel_mode_kept", bus.mode, 0);
        chk("cancel_in_ready_back", bus.in_ready, 1);
        tick(1);

        // Switch with four beats in flight
        for (int s = 0; s < 4; s++) send_front(mk(s + 810), mk(s + 820), mulv(mk(s + 810), mk(s + 820)));
        bus.in_valid = 1'b0;
        bus.mode_req = 1'b1;
        n0 = n_out;
        tick(2);
        for (int s = 0; s < 4; s++) send_back(mk(s + 830), mk(s + 840), mk(s + 830));
        bus.bf_out_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.mode == 1'b1) seen = 1'b1;
            else chk("switch_in_ready_low", bus.in_ready, 0);
        end
        chk("switch_outs_drained", n_out - n0, 4);
        switch_mode(1'b1);

        // Occupancy cap (INTT pass-through front)
        for (int s = 0; s < MAX_INFLIGHT; s++) send_front(mk(s + 900), mk(s + 950), mk(s + 900));
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cap_in_ready_low", bus.in_ready, 0);
        tick(1);
        send_back(mk(1000), mk(1001), mulv(mk(1000), mk(1001)));
        bus.bf_out_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("cap_out_seen", bus.out_valid, 1);
        chk("cap_in_ready_still_low", bus.in_ready, 0);
        @(negedge clk);
        chk("cap_in_ready_reasserted", bus.in_ready, 1);
        tick(1);
        for (int s = 0; s < MAX_INFLIGHT - 1; s++) send_back(mk(s + 1010), mk(s + 1060), mulv(mk(s + 1010), mk(s + 1060)));
        bus.bf_out_valid = 1'b0;
        tick(MULT_LAT + 2);

        // Butterfly beat with nothing outstanding: processed, err sticky, occ stays at 0
        @(negedge clk);
        chk("err_before", bus.err, 0);
        tick(1);
        send_back(mk(1100), mk(1101), mulv(mk(1100), mk(1101)));
        bus.bf_out_valid = 1'b0;
        @(negedge clk);
        chk("err_set", bus.err, 1);
        tick(MULT_LAT + 3);
        @(negedge clk);
        chk("err_sticky", bus.err, 1);
        chk("occ_saturated_in_ready", bus.in_ready, 1);
        tick(1);

        // Reset in the middle of a stream
        for (int s = 0; s < 5; s++) send_front(mk(s + 1200), mk(s + 1210), mk(s + 1200));
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode_req = 1'b0;
        q_front.delete();
        q_back.delete();
        tick(1);
        @(negedge clk);
        chk("rst_mid_bf_in_valid", bus.bf_in_valid, 0);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_err", bus.err, 0);
        chk("rst_mid_mode", bus.mode, 0);
        chk("rst_mid_butterfly_input", bus.butterfly_input, 0);
        m_mode = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(MULT_LAT + 4);

        // Normal traffic after reset
        send_front(rep(5), rep(3), rep(15));
        bus.in_valid = 1'b0;
        tick(1);
        send_back(rep(9), rep(1), rep(9));
        bus.bf_out_valid = 1'b0;
        tick(MULT_LAT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
